// File: rtl/bidir_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : bidir_pkg                                                         |
// | Brief  : Shared types and widths for the half-duplex turnaround controller |
// | Rev    : 1.0                                                               |
// +----------------------------------------------------------------------------+
package bidir_pkg;

    localparam int TURN_CW       = 4;
    localparam int BEAT_CW       = 8;
    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [3:0] {
        ST_RX      = 4'b0001,
        ST_TURN_RT = 4'b0010,
        ST_TX      = 4'b0100,
        ST_TURN_TR = 4'b1000
    } state_t;

endpackage
`default_nettype wire

// File: rtl/bidir_turnaround_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : bidir_turnaround_ctrl_if                                          |
// | Brief  : Local handshake and pad-side signals of the turnaround controller |
// | Rev    : 1.0                                                               |
// +----------------------------------------------------------------------------+
interface bidir_turnaround_ctrl_if #(
    parameter int WIDTH = bidir_pkg::DEFAULT_WIDTH
);
    logic             tx_valid;
    logic [WIDTH-1:0] tx_data;
    logic             tx_ready;
    logic             rem_req;
    logic             rx_valid;
    logic [WIDTH-1:0] rx_data;
    logic [WIDTH-1:0] pad_i;
    logic [WIDTH-1:0] pad_o;
    logic             pad_oe;
    logic             contention_err;

    modport slave (
        input  tx_valid, tx_data, rem_req, pad_i,
        output tx_ready, rx_valid, rx_data, pad_o, pad_oe, contention_err
    );

    modport master (
        output tx_valid, tx_data, rem_req, pad_i,
        input  tx_ready, rx_valid, rx_data, pad_o, pad_oe, contention_err
    );
endinterface
`default_nettype wire

// File: rtl/turn_timer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : turn_timer                                                        |
// | Brief  : Dead-cycle counter; done on the TURN_CYCLES-th running cycle      |
// | Rev    : 1.0                                                               |
// +----------------------------------------------------------------------------+
module turn_timer
    import bidir_pkg::*;
#(
    parameter int TURN_CYCLES = 2
) (
    input  wire logic clk,
    input  wire logic rst_n,
    input  wire logic i_run,
    input  wire logic i_clr,
    output logic      o_done
);
    localparam logic [TURN_CW-1:0] c_last = TURN_CW'(TURN_CYCLES - 1);

    logic [TURN_CW-1:0] r_cnt;

    assign o_done = i_run && (r_cnt == c_last);

    // Self-clearing on completion so the next turnaround starts from zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clr || o_done || !i_run) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end
endmodule
`default_nettype wire

// File: rtl/bidir_turnaround_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : bidir_turnaround_ctrl                                             |
// | Brief  : Half-duplex pad direction control with dead turnaround cycles.    |
// |          Optional pad contention checker: BIDIR_CONTENTION_DETECT_EN       |
// | Rev    : 1.0                                                               |
// +----------------------------------------------------------------------------+
module bidir_turnaround_ctrl
    import bidir_pkg::*;
#(
    parameter int WIDTH       = DEFAULT_WIDTH,
    parameter int TURN_CYCLES = 2,
    parameter int HOLD_MAX    = 16
) (
    input  wire logic               clk,
    input  wire logic               rst_n,
    bidir_turnaround_ctrl_if.slave  bus
);
    localparam logic [BEAT_CW-1:0] c_hold_max = BEAT_CW'(HOLD_MAX);

    state_t             r_state;
    logic [BEAT_CW-1:0] r_beat_cnt;
    logic [WIDTH-1:0]   r_pad_o;
    logic [WIDTH-1:0]   r_rx_data;
    logic               r_pad_oe;
    logic               r_rx_valid;

    logic w_turn_run;
    logic w_turn_done;
    logic w_abort;
    logic w_release;
    logic w_tx_ready;
    logic w_hs;

    assign w_turn_run = (r_state == ST_TURN_RT) || (r_state == ST_TURN_TR);
    assign w_abort    = (r_state == ST_TURN_RT) && bus.rem_req;
    assign w_release  = bus.rem_req && (r_beat_cnt >= c_hold_max);
    assign w_tx_ready = (r_state == ST_TX) && !w_release;
    assign w_hs       = w_tx_ready && bus.tx_valid;

    turn_timer #(
        .TURN_CYCLES (TURN_CYCLES)
    ) u_turn_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_run  (w_turn_run),
        .i_clr  (w_abort),
        .o_done (w_turn_done)
    );

    // pad_oe is written alongside every transition into/out of TX so it is a clean flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_RX;
            r_pad_oe   <= 1'b0;
            r_pad_o    <= '0;
            r_rx_valid <= 1'b0;
            r_rx_data  <= '0;
            r_beat_cnt <= '0;
        end else begin
            r_rx_valid <= 1'b0;
            case (r_state)
                ST_RX: begin
                    r_rx_valid <= bus.rem_req;
                    r_rx_data  <= bus.pad_i;
                    if (bus.tx_valid && !bus.rem_req) begin
                        r_state <= ST_TURN_RT;
                    end
                end
                ST_TURN_RT: begin
                    if (bus.rem_req) begin
                        r_state <= ST_RX;
                    end else if (w_turn_done) begin
                        r_state    <= ST_TX;
                        r_pad_oe   <= 1'b1;
                        r_beat_cnt <= '0;
                    end
                end
                ST_TX: begin
                    if (w_hs) begin
                        r_pad_o <= bus.tx_data;
                        if (r_beat_cnt != '1) begin
                            r_beat_cnt <= r_beat_cnt + 1'b1;
                        end
                    end else begin
                        r_state  <= ST_TURN_TR;
                        r_pad_oe <= 1'b0;
                    end
                end
                ST_TURN_TR: begin
                    if (w_turn_done) begin
                        r_state <= ST_RX;
                    end
                end
                default: begin
                    r_state  <= ST_RX;
                    r_pad_oe <= 1'b0;
                end
            endcase
        end
    end

    assign bus.tx_ready = w_tx_ready;
    assign bus.pad_o    = r_pad_o;
    assign bus.pad_oe   = r_pad_oe;
    assign bus.rx_valid = r_rx_valid;
    assign bus.rx_data  = r_rx_data;

`ifdef BIDIR_CONTENTION_DETECT_EN
    logic r_tx_prev;
    logic r_contention;

    // The first TX cycle is skipped: the pad is still settling from high-Z.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tx_prev    <= 1'b0;
            r_contention <= 1'b0;
        end else begin
            r_tx_prev <= (r_state == ST_TX);
            if ((r_state == ST_TX) && r_tx_prev && (bus.pad_i != r_pad_o)) begin
                r_contention <= 1'b1;
            end
        end
    end

    assign bus.contention_err = r_contention;
`else
    assign bus.contention_err = 1'b0;
`endif
endmodule
`default_nettype wire

// File: tb/tb_bidir_turnaround_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : tb_bidir_turnaround_ctrl                                          |
// | Brief  : Scoreboard bench for bidir_turnaround_ctrl (HOLD_MAX=4)           |
// | Rev    : 1.0                                                               |
// +----------------------------------------------------------------------------+
module tb_bidir_turnaround_ctrl;

`ifdef BIDIR_CONTENTION_DETECT_EN
    localparam logic c_exp_cont = 1'b1;
`else
    localparam logic c_exp_cont = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] drv_pad;
    logic       force_en;
    logic       hs;
    int         k;
    int         got;
    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] txq[$];
    logic [7:0] rxq[$];
    logic [7:0] mon_exp;

    bidir_turnaround_ctrl_if #(.WIDTH(8)) bus ();

    bidir_turnaround_ctrl #(
        .WIDTH       (8),
        .TURN_CYCLES (2),
        .HOLD_MAX    (4)
    ) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Pad model: loopback while driving (optionally corrupted), far-end value otherwise.
    assign bus.pad_i = bus.pad_oe ? (force_en ? 8'hFF : bus.pad_o) : drv_pad;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_beats(input int n, input logic [7:0] d0, output int cnt);
        logic h;
        bus.tx_valid = 1'b1;
        bus.tx_data  = d0;
        cnt = 0;
        for (int g = 0; g < 40 && cnt < n; g++) begin
            @(negedge clk);
            h = bus.tx_valid && bus.tx_ready;
            tick();
            if (h) begin
                cnt++;
                bus.tx_data = d0 + 8'(cnt);
            end
        end
        bus.tx_valid = 1'b0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_oe"},   32'(bus.pad_oe), 0);
        chk({tag, "_pado"}, 32'(bus.pad_o), 0);
        chk({tag, "_rdy"},  32'(bus.tx_ready), 0);
        chk({tag, "_rxv"},  32'(bus.rx_valid), 0);
        chk({tag, "_rxd"},  32'(bus.rx_data), 0);
        chk({tag, "_cerr"}, 32'(bus.contention_err), 0);
    endtask

    // Scoreboard monitor: beats accepted one cycle must appear on the pad the next.
    always @(negedge clk) begin
        if (!rst_n) begin
            txq.delete();
            chk("rst_pad_oe", 32'(bus.pad_oe), 0);
        end else begin
            if (txq.size() > 0) begin
                mon_exp = txq.pop_front();
                chk("beat_data", 32'(bus.pad_o), 32'(mon_exp));
                chk("beat_oe", 32'(bus.pad_oe), 1);
            end
            if (bus.tx_valid && bus.tx_ready) begin
                txq.push_back(bus.tx_data);
            end
            if (bus.rx_valid) begin
                chk("rx_pending", 32'(rxq.size() > 0), 1);
                if (rxq.size() > 0) begin
                    mon_exp = rxq.pop_front();
                    chk("rx_data", 32'(bus.rx_data), 32'(mon_exp));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n        = 1'b0;
        bus.tx_valid = 1'b0;
        bus.tx_data  = 8'h00;
        bus.rem_req  = 1'b0;
        drv_pad      = 8'h00;
        force_en     = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_vals("reset");
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        tick();

        // Single beat through RX -> TURN_RT -> TX -> TURN_TR -> RX
        bus.tx_valid = 1'b1;
        bus.tx_data  = 8'hA5;
        tick(); chk("rt1_oe", 32'(bus.pad_oe), 0); chk("rt1_rdy", 32'(bus.tx_ready), 0);
        tick(); chk("rt2_oe", 32'(bus.pad_oe), 0);
        tick(); chk("tx_oe", 32'(bus.pad_oe), 1); chk("tx_rdy", 32'(bus.tx_ready), 1);
        tick(); chk("a5_pado", 32'(bus.pad_o), 32'h A5);
        bus.tx_valid = 1'b0;
        tick(); chk("tr_oe", 32'(bus.pad_oe), 0);
        tick();
        tick();

        // Four-beat burst then idle
        send_beats(4, 8'h01, got);
        chk("burst_n", got, 4);
        chk("burst_last_oe", 32'(bus.pad_oe), 1);
        tick(); chk("burst_oe_fall", 32'(bus.pad_oe), 0);
        tick();
        tick();

        // Far end drives three beats; RX must be live right now
        bus.rem_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drv_pad = 8'h3C + 8'(i);
            rxq.push_back(drv_pad);
            tick();
            chk("rx_v", 32'(bus.rx_valid), 1);
            chk("rx_oe", 32'(bus.pad_oe), 0);
        end
        bus.rem_req = 1'b0;
        tick(); chk("rx_v_end", 32'(bus.rx_valid), 0);

        // Simultaneous request: far end wins
        bus.rem_req  = 1'b1;
        bus.tx_valid = 1'b1;
        bus.tx_data  = 8'h99;
        for (int i = 0; i < 3; i++) begin
            drv_pad = 8'h50 + 8'(i);
            rxq.push_back(drv_pad);
            tick();
            chk("col_rdy", 32'(bus.tx_ready), 0);
            chk("col_oe", 32'(bus.pad_oe), 0);
        end

        // Abort in TURN_RT
        bus.rem_req = 1'b0;
        tick(); chk("ab_oe0", 32'(bus.pad_oe), 0);
        bus.rem_req = 1'b1;
        drv_pad     = 8'h77;
        tick(); chk("ab_oe1", 32'(bus.pad_oe), 0);
        rxq.push_back(drv_pad);
        tick(); chk("ab_rxv", 32'(bus.rx_valid), 1); chk("ab_oe2", 32'(bus.pad_oe), 0);
        bus.rem_req  = 1'b0;
        bus.tx_valid = 1'b0;
        tick(); chk("ab_oe3", 32'(bus.pad_oe), 0);
        tick();

        // Hold limit with far end waiting from the 2nd beat
        drv_pad      = 8'hC0;
        bus.tx_valid = 1'b1;
        bus.tx_data  = 8'h10;
        tick();
        tick();
        tick(); chk("hold_rdy0", 32'(bus.tx_ready), 1);
        k = 0;
        for (int g = 0; g < 20; g++) begin
            @(negedge clk);
            hs = bus.tx_valid && bus.tx_ready;
            tick();
            if (!hs) break;
            k++;
            if (k == 1) bus.rem_req = 1'b1;
            bus.tx_data = 8'h10 + 8'(k);
        end
        bus.tx_valid = 1'b0;
        chk("hold_beats", k, 4);
        chk("hold_tr_oe", 32'(bus.pad_oe), 0);
        chk("hold_rxv0", 32'(bus.rx_valid), 0);
        tick(); chk("hold_rxv1", 32'(bus.rx_valid), 0);
        tick(); chk("hold_rxv2", 32'(bus.rx_valid), 0);
        rxq.push_back(drv_pad);
        tick(); chk("hold_rxv3", 32'(bus.rx_valid), 1);
        bus.rem_req = 1'b0;
        tick();

        // Pad contention while driving zeros
        bus.tx_valid = 1'b1;
        bus.tx_data  = 8'h00;
        tick();
        tick();
        tick();
        tick();
        force_en = 1'b1;
        tick(); chk("cont_set", 32'(bus.contention_err), 32'(c_exp_cont));
        force_en     = 1'b0;
        bus.tx_valid = 1'b0;
        repeat (4) tick();
        chk("cont_hold", 32'(bus.contention_err), 32'(c_exp_cont));

        // Asynchronous reset mid-burst
        bus.tx_valid = 1'b1;
        bus.tx_data  = 8'h20;
        tick();
        tick();
        tick();
        tick(); chk("pre_rst_oe", 32'(bus.pad_oe), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_vals("midrst");
        bus.tx_valid = 1'b0;
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        tick();
        chk("post_rst_oe", 32'(bus.pad_oe), 0);
        chk("post_rst_rdy", 32'(bus.tx_ready), 0);
        chk("post_rst_rxv", 32'(bus.rx_valid), 0);
        tick();

        chk("txq_empty", 32'(txq.size()), 0);
        chk("rxq_empty", 32'(rxq.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
